// File: rtl/video_frame_scheduler.sv
// -----------------------------------------------------------------------------
// video_frame_scheduler
//
// Purpose:
//   Raster timing generator for the colour-bar video datapath. It keeps
//   video_x/video_y counters, decodes the sync strobes, the visible flag and
//   the line/frame start pulses from those counters, and counts completed
//   frames. It also double-buffers mouse samples so that the mouse state seen
//   by the pixel logic changes only at the start of a frame.
//
// Ports:
//   clock             in   pixel clock, rising edge
//   reset_            in   asynchronous active-low reset
//   mouse_valid       in   single-cycle strobe, mouse_*_in hold a new sample
//   mouse_x_in        in   [8:0] new mouse x
//   mouse_y_in        in   [8:0] new mouse y
//   mouse_pressed_in_ in   new button state, active low
//   video_x           out  [8:0] current pixel column
//   video_y           out  [8:0] current line
//   hsync_            out  horizontal sync, active low
//   vsync_            out  vertical sync, active low
//   visible           out  high inside the visible window
//   line_start        out  high while video_x == 0
//   frame_start       out  high while video_x == 0 and video_y == 0
//   mouse_x           out  [8:0] mouse x, stable for the whole frame
//   mouse_y           out  [8:0] mouse y, stable for the whole frame
//   mouse_pressed_    out  button state, stable for the whole frame
//   frame_count       out  [15:0] completed frames, wraps 65535 -> 0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module video_frame_scheduler #(
   parameter int unsigned H_TOTAL      = 448,
   parameter int unsigned V_TOTAL      = 312,
   parameter int unsigned H_VISIBLE    = 352,
   parameter int unsigned V_VISIBLE    = 288,
   parameter int unsigned H_SYNC_START = 384,
   parameter int unsigned H_SYNC_WIDTH = 32,
   parameter int unsigned V_SYNC_START = 296,
   parameter int unsigned V_SYNC_WIDTH = 4
) (
   input  logic        clock,
   input  logic        reset_,
   input  logic        mouse_valid,
   input  logic [8:0]  mouse_x_in,
   input  logic [8:0]  mouse_y_in,
   input  logic        mouse_pressed_in_,
   output logic [8:0]  video_x,
   output logic [8:0]  video_y,
   output logic        hsync_,
   output logic        vsync_,
   output logic        visible,
   output logic        line_start,
   output logic        frame_start,
   output logic [8:0]  mouse_x,
   output logic [8:0]  mouse_y,
   output logic        mouse_pressed_,
   output logic [15:0] frame_count
);

   // Parameter sanity checks, evaluated at elaboration only.
   if (H_TOTAL < 2 || H_TOTAL > 512) begin : g_chk_htotal
      $error("H_TOTAL out of range");
   end
   if (V_TOTAL < 2 || V_TOTAL > 512) begin : g_chk_vtotal
      $error("V_TOTAL out of range");
   end
   if (H_VISIBLE < 1 || H_VISIBLE > H_TOTAL) begin : g_chk_hvis
      $error("H_VISIBLE out of range");
   end
   if (V_VISIBLE < 1 || V_VISIBLE > V_TOTAL) begin : g_chk_vvis
      $error("V_VISIBLE out of range");
   end
   if (H_SYNC_START + H_SYNC_WIDTH > H_TOTAL) begin : g_chk_hsync
      $error("horizontal sync window wraps past H_TOTAL-1");
   end
   if (V_SYNC_START + V_SYNC_WIDTH > V_TOTAL) begin : g_chk_vsync
      $error("vertical sync window wraps past V_TOTAL-1");
   end

   // Window bounds are 10 bits wide so that an end bound of 512 is representable.
   localparam logic [8:0] X_LAST = 9'(H_TOTAL - 1);
   localparam logic [8:0] Y_LAST = 9'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_BEG = 10'(H_SYNC_START);
   localparam logic [9:0] HS_END = 10'(H_SYNC_START + H_SYNC_WIDTH);
   localparam logic [9:0] VS_BEG = 10'(V_SYNC_START);
   localparam logic [9:0] VS_END = 10'(V_SYNC_START + V_SYNC_WIDTH);

   logic [8:0]  x_q, x_d;
   logic [8:0]  y_q, y_d;
   logic [15:0] frame_count_q, frame_count_d;

   // Published (frame-stable) mouse state.
   logic [8:0]  mouse_x_q, mouse_x_d;
   logic [8:0]  mouse_y_q, mouse_y_d;
   logic        mouse_pressed_q, mouse_pressed_d;

   // Pending sample, waiting for the next frame wrap.
   logic [8:0]  pend_x_q, pend_x_d;
   logic [8:0]  pend_y_q, pend_y_d;
   logic        pend_pressed_q, pend_pressed_d;
   logic        pend_valid_q, pend_valid_d;

   logic        x_last, y_last, frame_wrap;
   logic [9:0]  x_ext, y_ext;

   assign x_last     = (x_q == X_LAST);
   assign y_last     = (y_q == Y_LAST);
   assign frame_wrap = x_last && y_last;

   // NOTE: every variable driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      x_d             = x_last ? 9'd0 : x_q + 9'd1;
      y_d             = y_q;
      frame_count_d   = frame_count_q;
      mouse_x_d       = mouse_x_q;
      mouse_y_d       = mouse_y_q;
      mouse_pressed_d = mouse_pressed_q;
      pend_x_d        = pend_x_q;
      pend_y_d        = pend_y_q;
      pend_pressed_d  = pend_pressed_q;
      pend_valid_d    = pend_valid_q;

      if (x_last) begin
         y_d = y_last ? 9'd0 : y_q + 9'd1;
      end

      // Publish uses the pending value as it stood before this edge, so a
      // sample arriving on the wrap edge itself waits for the following frame.
      if (frame_wrap) begin
         frame_count_d = frame_count_q + 16'd1;
         if (pend_valid_q) begin
            mouse_x_d       = pend_x_q;
            mouse_y_d       = pend_y_q;
            mouse_pressed_d = pend_pressed_q;
         end
         pend_valid_d = 1'b0;
      end

      // Last sample in a frame wins.
      if (mouse_valid) begin
         pend_x_d       = mouse_x_in;
         pend_y_d       = mouse_y_in;
         pend_pressed_d = mouse_pressed_in_;
         pend_valid_d   = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; the reset branch is asynchronous and needs no clock.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         x_q             <= 9'd0;
         y_q             <= 9'd0;
         frame_count_q   <= 16'd0;
         mouse_x_q       <= 9'd0;
         mouse_y_q       <= 9'd0;
         mouse_pressed_q <= 1'b1;
         pend_x_q        <= 9'd0;
         pend_y_q        <= 9'd0;
         pend_pressed_q  <= 1'b1;
         pend_valid_q    <= 1'b0;
      end else begin
         x_q             <= x_d;
         y_q             <= y_d;
         frame_count_q   <= frame_count_d;
         mouse_x_q       <= mouse_x_d;
         mouse_y_q       <= mouse_y_d;
         mouse_pressed_q <= mouse_pressed_d;
         pend_x_q        <= pend_x_d;
         pend_y_q        <= pend_y_d;
         pend_pressed_q  <= pend_pressed_d;
         pend_valid_q    <= pend_valid_d;
      end
   end

   // Strobes decode straight from the counter flops, so they move on the same
   // edge as video_x/video_y with no pipeline skew.
   assign x_ext = {1'b0, x_q};
   assign y_ext = {1'b0, y_q};

   assign hsync_      = ~((x_ext >= HS_BEG) && (x_ext < HS_END));
   assign vsync_      = ~((y_ext >= VS_BEG) && (y_ext < VS_END));
   assign visible     = (x_ext < H_VIS) && (y_ext < V_VIS);
   assign line_start  = (x_q == 9'd0);
   assign frame_start = (x_q == 9'd0) && (y_q == 9'd0);

   assign video_x        = x_q;
   assign video_y        = y_q;
   assign frame_count    = frame_count_q;
   assign mouse_x        = mouse_x_q;
   assign mouse_y        = mouse_y_q;
   assign mouse_pressed_ = mouse_pressed_q;

endmodule

// File: tb/tb_video_frame_scheduler.sv
`timescale 1ns/1ps

module tb_video_frame_scheduler;

   localparam int HT  = 8;
   localparam int VT  = 4;
   localparam int HV  = 6;
   localparam int VV  = 3;
   localparam int HSS = 6;
   localparam int HSW = 1;
   localparam int VSS = 3;
   localparam int VSW = 1;

   typedef struct packed {
      logic [8:0]  x;
      logic [8:0]  y;
      logic        hs;
      logic        vs;
      logic        vis;
      logic        ls;
      logic        fs;
      logic [8:0]  mx;
      logic [8:0]  my;
      logic        mp;
      logic [15:0] fc;
   } obs_t;

   logic        clock;
   logic        reset_;
   logic        mouse_valid;
   logic [8:0]  mouse_x_in;
   logic [8:0]  mouse_y_in;
   logic        mouse_pressed_in_;
   logic [8:0]  video_x;
   logic [8:0]  video_y;
   logic        hsync_;
   logic        vsync_;
   logic        visible;
   logic        line_start;
   logic        frame_start;
   logic [8:0]  mouse_x;
   logic [8:0]  mouse_y;
   logic        mouse_pressed_;
   logic [15:0] frame_count;

   int errors = 0;
   int checks = 0;

   // Reference model state.
   int          m_x, m_y;
   logic [15:0] m_fc;
   logic [8:0]  m_mx, m_my, m_px, m_py;
   logic        m_mp, m_pp, m_pend;

   obs_t sb[$];

   video_frame_scheduler #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_VISIBLE(HV), .V_VISIBLE(VV),
      .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
      .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW)
   ) dut (
      .clock(clock),
      .reset_(reset_),
      .mouse_valid(mouse_valid),
      .mouse_x_in(mouse_x_in),
      .mouse_y_in(mouse_y_in),
      .mouse_pressed_in_(mouse_pressed_in_),
      .video_x(video_x),
      .video_y(video_y),
      .hsync_(hsync_),
      .vsync_(vsync_),
      .visible(visible),
      .line_start(line_start),
      .frame_start(frame_start),
      .mouse_x(mouse_x),
      .mouse_y(mouse_y),
      .mouse_pressed_(mouse_pressed_),
      .frame_count(frame_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic obs_t sample_dut();
      obs_t o;
      o = '{x: video_x, y: video_y, hs: hsync_, vs: vsync_, vis: visible,
            ls: line_start, fs: frame_start, mx: mouse_x, my: mouse_y,
            mp: mouse_pressed_, fc: frame_count};
      return o;
   endfunction

   function automatic obs_t model_expect();
      obs_t e;
      e.x   = 9'(m_x);
      e.y   = 9'(m_y);
      e.hs  = !(m_x >= HSS && m_x < HSS + HSW);
      e.vs  = !(m_y >= VSS && m_y < VSS + VSW);
      e.vis = (m_x < HV) && (m_y < VV);
      e.ls  = (m_x == 0);
      e.fs  = (m_x == 0) && (m_y == 0);
      e.mx  = m_mx;
      e.my  = m_my;
      e.mp  = m_mp;
      e.fc  = m_fc;
      return e;
   endfunction

   task automatic model_reset();
      m_x = 0; m_y = 0; m_fc = 16'd0;
      m_mx = 9'd0; m_my = 9'd0; m_mp = 1'b1;
      m_px = 9'd0; m_py = 9'd0; m_pp = 1'b1; m_pend = 1'b0;
   endtask

   // One clock: drive inputs, advance the model and queue its prediction,
   // then return what the DUT shows #1 after the edge with the popped entry.
   task automatic step(input logic v, input logic [8:0] xi, input logic [8:0] yi,
                       input logic pi, output obs_t obs, output obs_t exp);
      mouse_valid       = v;
      mouse_x_in        = xi;
      mouse_y_in        = yi;
      mouse_pressed_in_ = pi;
      if (m_x == HT - 1 && m_y == VT - 1) begin
         m_fc = m_fc + 16'd1;
         if (m_pend) begin
            m_mx = m_px; m_my = m_py; m_mp = m_pp;
         end
         m_pend = 1'b0;
      end
      if (v) begin
         m_px = xi; m_py = yi; m_pp = pi; m_pend = 1'b1;
      end
      if (m_x == HT - 1) begin
         m_x = 0;
         m_y = (m_y == VT - 1) ? 0 : m_y + 1;
      end else begin
         m_x = m_x + 1;
      end
      sb.push_back(model_expect());
      @(posedge clock);
      #1;
      mouse_valid = 1'b0;
      obs = sample_dut();
      exp = sb.pop_front();
   endtask

   // Idle-step until the model sits at (tx,ty), checking every cycle.
   task automatic run_to(input int tx, input int ty);
      obs_t o, e;
      for (int n = 0; n < 4 * HT * VT && !(m_x == tx && m_y == ty); n++) begin
         step(1'b0, 9'd0, 9'd0, 1'b1, o, e);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL run_to cycle: got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_reset();
      obs_t o, e;
      reset_ = 1'b1;
      mouse_valid = 1'b0; mouse_x_in = '0; mouse_y_in = '0; mouse_pressed_in_ = 1'b1;
      #1 reset_ = 1'b0;
      #2;
      model_reset();
      o = sample_dut();
      e = model_expect();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL reset_state: got %h want %h", o, e);
      end
      checks++;
      if ({line_start, frame_start, visible, hsync_, vsync_} !== 5'b11111) begin
         errors++;
         $display("FAIL reset_strobes: got %b want 11111",
                  {line_start, frame_start, visible, hsync_, vsync_});
      end
      @(negedge clock);
      reset_ = 1'b1;
   endtask

   task automatic test_counters();
      obs_t o, e;
      for (int i = 1; i <= 64; i++) begin
         step(1'b0, 9'd0, 9'd0, 1'b1, o, e);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL counters cycle %0d: got %h want %h", i, o, e);
         end
         if (i == 1) begin
            checks++;
            if (video_x !== 9'd1) begin
               errors++;
               $display("FAIL first_edge_x: got %0d want 1", video_x);
            end
         end
         if (i == 8) begin
            checks++;
            if (video_x !== 9'd0 || video_y !== 9'd1) begin
               errors++;
               $display("FAIL line_wrap: got x=%0d y=%0d want x=0 y=1", video_x, video_y);
            end
         end
         if (i == 32 || i == 64) begin
            checks++;
            if (frame_start !== 1'b1) begin
               errors++;
               $display("FAIL frame_start cycle %0d: got %b want 1", i, frame_start);
            end
         end
      end
      checks++;
      if (frame_count !== 16'd2) begin
         errors++;
         $display("FAIL frame_count_64: got %0d want 2", frame_count);
      end
   endtask

   task automatic test_decode();
      obs_t o, e;
      int hs_low, vs_low, vis_hi, hs_bad;
      hs_low = 0; vs_low = 0; vis_hi = 0; hs_bad = 0;
      for (int i = 0; i < HT * VT; i++) begin
         step(1'b0, 9'd0, 9'd0, 1'b1, o, e);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL decode cycle %0d: got %h want %h", i, o, e);
         end
         if (!hsync_) hs_low++;
         if (!hsync_ && video_x != 9'd6) hs_bad++;
         if (!vsync_) vs_low++;
         if (visible) vis_hi++;
      end
      checks++;
      if (hs_low !== 4 || hs_bad !== 0) begin
         errors++;
         $display("FAIL hsync_count: got %0d (off-x %0d) want 4 (0)", hs_low, hs_bad);
      end
      checks++;
      if (vs_low !== 8) begin
         errors++;
         $display("FAIL vsync_count: got %0d want 8", vs_low);
      end
      checks++;
      if (vis_hi !== 18) begin
         errors++;
         $display("FAIL visible_count: got %0d want 18", vis_hi);
      end
   endtask

   task automatic test_mouse_last_wins();
      obs_t o, e;
      run_to(2, 1);
      step(1'b1, 9'd100, 9'd50, 1'b0, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL mouse_s1: got %h want %h", o, e); end
      run_to(4, 1);
      step(1'b1, 9'd120, 9'd60, 1'b1, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL mouse_s2: got %h want %h", o, e); end
      run_to(7, 3);
      checks++;
      if ({mouse_x, mouse_y, mouse_pressed_} !== {9'd0, 9'd0, 1'b1}) begin
         errors++;
         $display("FAIL mouse_before_wrap: got %0d,%0d,%b want 0,0,1",
                  mouse_x, mouse_y, mouse_pressed_);
      end
      for (int i = 0; i <= HT * VT; i++) begin
         step(1'b0, 9'd0, 9'd0, 1'b1, o, e);
         checks++;
         if (o !== e || {mouse_x, mouse_y, mouse_pressed_} !== {9'd120, 9'd60, 1'b1}) begin
            errors++;
            $display("FAIL mouse_published %0d: got %h want %h (mouse 120,60,1)", i, o, e);
         end
      end
   endtask

   task automatic test_wrap_coincident();
      obs_t o, e;
      run_to(3, 0);
      step(1'b1, 9'd3, 9'd3, 1'b1, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL coinc_pend: got %h want %h", o, e); end
      run_to(7, 3);
      step(1'b1, 9'd7, 9'd7, 1'b0, o, e);
      checks++;
      if (o !== e || {mouse_x, mouse_y, mouse_pressed_} !== {9'd3, 9'd3, 1'b1}) begin
         errors++;
         $display("FAIL coinc_first: got %0d,%0d,%b want 3,3,1", mouse_x, mouse_y, mouse_pressed_);
      end
      run_to(7, 3);
      step(1'b0, 9'd0, 9'd0, 1'b1, o, e);
      checks++;
      if (o !== e || {mouse_x, mouse_y, mouse_pressed_} !== {9'd7, 9'd7, 1'b0}) begin
         errors++;
         $display("FAIL coinc_second: got %0d,%0d,%b want 7,7,0", mouse_x, mouse_y, mouse_pressed_);
      end
   endtask

   task automatic test_reset_mid_frame();
      obs_t o, e;
      run_to(1, 1);
      step(1'b1, 9'd9, 9'd9, 1'b0, o, e);
      run_to(5, 2);
      reset_ = 1'b0;
      #1;
      model_reset();
      o = sample_dut();
      e = model_expect();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL mid_reset_async: got %h want %h", o, e);
      end
      @(negedge clock);
      reset_ = 1'b1;
      run_to(7, 3);
      step(1'b0, 9'd0, 9'd0, 1'b1, o, e);
      checks++;
      if (o !== e || {mouse_x, mouse_y, mouse_pressed_} !== {9'd0, 9'd0, 1'b1}) begin
         errors++;
         $display("FAIL mid_reset_discard: got %0d,%0d,%b want 0,0,1",
                  mouse_x, mouse_y, mouse_pressed_);
      end
   endtask

   task automatic test_frame_count_wrap();
      obs_t o, e;
      run_to(2, 1);
      force dut.frame_count_q = 16'hFFFF;
      #1;
      release dut.frame_count_q;
      m_fc = 16'hFFFF;
      checks++;
      if (frame_count !== 16'hFFFF) begin
         errors++;
         $display("FAIL fc_preload: got %0d want 65535", frame_count);
      end
      run_to(7, 3);
      step(1'b0, 9'd0, 9'd0, 1'b1, o, e);
      checks++;
      if (o !== e || frame_count !== 16'd0) begin
         errors++;
         $display("FAIL fc_wrap: got %0d want 0", frame_count);
      end
   endtask

   initial begin
      test_reset();
      test_counters();
      test_decode();
      test_mouse_last_wins();
      test_wrap_coincident();
      test_reset_mid_frame();
      test_frame_count_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
